serial_adder_word_sequencer: RTL and testbench
==============================================

// Module: serial_adder_word_sequencer
//
// PURPOSE
//   Word-level controller around a 1-bit serial adder datapath. Accepts two
//   WIDTH-bit operands over a valid/ready handshake and feeds them LSB-first,
//   one bit per clock, through an internal full-adder slice with a carry flop.
//   Collects the sum bits and returns the WIDTH-bit sum and carry-out over a
//   second valid/ready handshake. Clears the carry at the start of every word.
//   Lets word-oriented logic reuse the bit-serial adder without bit sequencing.
//
// PARAMETERS
//   WIDTH  16  operand/sum width in bits; legal range 2..64
//
// PORTS
//   clk        in   1      clock; all state changes on posedge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      operands a/b valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  operand A, sampled only on accept
//   b          in   WIDTH  operand B, sampled only on accept
//   out_valid  out  1      sum/carry_out valid (high only in DONE)
//   out_ready  in   1      consumer takes result
//   sum        out  WIDTH  (a + b) mod 2**WIDTH, registered
//   carry_out  out  1      carry out of bit WIDTH-1, registered
//   busy       out  1      high in RUN
//
// BEHAVIOUR
//   - One clock, synchronous active-high reset on rst; one clock domain.
//   - Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, carry_out=0,
//     carry flop=0, bit counter=0. rst at any edge (incl. mid-RUN or DONE)
//     aborts the word; no partial result ever appears on out_valid.
//   - FSM IDLE -> RUN -> DONE -> IDLE:
//     IDLE: accept edge = in_valid & in_ready. Load a/b into shift registers,
//       carry=0, cnt=0, go RUN.
//     RUN: each edge: s = a_sr[0]^b_sr[0]^c; c = maj(a_sr[0],b_sr[0],c);
//       shift a_sr/b_sr right; shift s into sum_sr at MSB; cnt++.
//       Edge with cnt==WIDTH-1 is the last bit: go DONE, sum <= final sum_sr,
//       carry_out <= final c.
//     DONE: out_valid=1; sum/carry_out held stable. Edge with out_ready=1:
//       go IDLE, out_valid drops next cycle.
//   - Latency: accept at edge E; RUN edges E+1..E+WIDTH; out_valid=1 from
//     after edge E+WIDTH. Min word period WIDTH+2 cycles (out_ready tied high).
//   - in_ready=0 in RUN/DONE; in_valid there is ignored, a/b changes after
//     accept have no effect. No new operand accepted in same edge as output
//     handshake.
//   - out_ready outside DONE ignored. Arbitrary out_valid stall holds
//     sum/carry_out unchanged.
//   - Carry never leaks between words: cleared on each accept.
//   - Adder slice built from logic operators only (^, &, |); no '+' operator.
//   - Counter width $clog2(WIDTH); no wrap in RUN since exit at WIDTH-1.
//
// TESTING  (WIDTH=16, out_ready=1 unless stated)
//   1. a=16'h4DB4, b=16'h1D62 -> out_valid exactly 16 cycles after accept
//      edge; sum=16'h6B16, carry_out=0.
//   2. a=16'hFFFF, b=16'h0001 -> sum=16'h0000, carry_out=1; next word
//      a=16'h0001, b=16'h0001 -> sum=16'h0002, carry_out=0 (carry cleared).
//   3. Backpressure: a=16'h8000, b=16'h8000, out_ready=0 for 5 cycles in
//      DONE -> out_valid, sum=0, carry_out=1 stable; in_ready=0 throughout.
//   4. in_valid held high with changing a/b during RUN -> result reflects only
//      accepted operands; no second accept until back in IDLE.
//   5. rst pulsed 1 cycle at bit 7 of RUN -> IDLE, outputs at reset values,
//      no out_valid; next word 16'h1234+16'h4321 -> sum=16'h5555, cout=0.
//   6. Random 1000 words vs golden {carry,sum}=a+b, random in_valid and
//      out_ready gaps -> all match, no dropped or duplicated result.

Source files
------------

// File: rtl/serial_adder_word_sequencer.sv
// Word-level wrapper around a 1-bit serial full adder: accepts a/b, adds LSB-first, returns sum/carry_out.
// Latency WIDTH cycles from accept to out_valid; in_ready only in IDLE, result held while out_ready is low.
module serial_adder_word_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             c;
  logic [CW-1:0]    cnt;
  logic             s_bit;
  logic             c_next;

  // Full-adder slice on the current LSBs and the carry flop.
  assign s_bit  = a_sr[0] ^ b_sr[0] ^ c;
  assign c_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      sum_sr    <= '0;
      c         <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= a;
            b_sr     <= b;
            sum_sr   <= '0;
            c        <= 1'b0;
            cnt      <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= {s_bit, sum_sr[WIDTH-1:1]};
          c      <= c_next;
          cnt    <= cnt + 1'b1;
          // Last bit: publish the completed word straight from the slice outputs.
          if (cnt == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            sum       <= {s_bit, sum_sr[WIDTH-1:1]};
            carry_out <= c_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_word_sequencer.sv
// Bench for serial_adder_word_sequencer: directed words with literal sums plus random traffic vs a word-level model.
module tb_serial_adder_word_sequencer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         busy;

  int tests = 0;
  int fails = 0;

  serial_adder_word_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Word-level model: phase 0 idle, 1..W bits in flight, W+1 result presented.
  int           ph = 0;
  logic [W:0]   pend = '0;
  logic [W-1:0] msum = '0;
  logic         mc = 1'b0;
  bit           started = 0;
  int           acc_cnt = 0;
  int           done_cnt = 0;
  int           dut_out_cnt = 0;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) dut_out_cnt++;
    if (rst) begin
      ph = 0; msum = '0; mc = 1'b0;
    end else if (ph == 0) begin
      if (in_valid) begin
        pend = {1'b0, a} + {1'b0, b};
        ph = 1;
        acc_cnt++;
      end
    end else if (ph < W) begin
      ph++;
    end else if (ph == W) begin
      ph = W + 1;
      {mc, msum} = pend;
    end else if (out_ready) begin
      ph = 0;
      done_cnt++;
    end
    if (rst) started = 1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("cycle {in_ready,busy,out_valid,carry,sum}",
          {45'd0, in_ready, busy, out_valid, carry_out, sum},
          {45'd0, ph == 0, (ph >= 1 && ph <= W), ph == W + 1, mc, msum});
    end
  end

  // Call #1 after a posedge with the DUT idle; the next edge is the accept edge.
  task automatic run_word(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [W-1:0] es, input logic ec,
                          input int stall, input bit churn, input string nm);
    int n;
    a = ta; b = tb_v; in_valid = 1'b1; out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = churn;
    n = 0;
    while (!out_valid && n < 100) begin
      if (churn) begin a = W'($urandom); b = W'($urandom); end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk({nm, " latency"}, n, W);
    chk({nm, " sum"}, sum, es);
    chk({nm, " carry_out"}, carry_out, ec);
    for (int i = 0; i < stall; i++) begin
      chk({nm, " stall {out_valid,in_ready,carry,sum}"},
          {out_valid, in_ready, carry_out, sum}, {1'b1, 1'b0, ec, es});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, " out_valid drop"}, out_valid, 1'b0);
  endtask

  initial begin
    int cyc;
    int base;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset {in_ready,out_valid,busy,carry,sum}",
        {in_ready, out_valid, busy, carry_out, sum}, {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    rst = 1'b0;
    @(posedge clk); #1;

    run_word(16'h4DB4, 16'h1D62, 16'h6B16, 1'b0, 0, 0, "t1");
    run_word(16'hFFFF, 16'h0001, 16'h0000, 1'b1, 0, 0, "t2a");
    run_word(16'h0001, 16'h0001, 16'h0002, 1'b0, 0, 0, "t2b");
    run_word(16'h8000, 16'h8000, 16'h0000, 1'b1, 5, 0, "t3");
    run_word(16'h0F0F, 16'h00F1, 16'h1000, 1'b0, 0, 1, "t4");

    // Abort a word mid-flight with a one-cycle reset.
    a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5 after rst {in_ready,out_valid,busy,carry,sum}",
        {in_ready, out_valid, busy, carry_out, sum}, {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    repeat (20) begin @(posedge clk); #1; end
    chk("t5 no result after abort", out_valid, 1'b0);
    run_word(16'h1234, 16'h4321, 16'h5555, 1'b0, 0, 0, "t5");

    // Random traffic with input and output gaps.
    base = acc_cnt;
    cyc = 0;
    while (acc_cnt < base + 1000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2 * W + 4) begin @(posedge clk); #1; end
    chk("random words accepted", acc_cnt - base, 1000);
    chk("results delivered vs accepted", done_cnt, acc_cnt - 1);
    chk("dut handshakes vs model", dut_out_cnt, done_cnt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
